// File: rtl/red_or_seq_pkg.sv
// Shared types and sizing helpers for the word-serial OR-reduction engine.
package red_or_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int ceil_div(input int n, input int d);
      return (n + d - 1) / d;
   endfunction

   // A single chunk still needs a one-bit index field.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/red_or_seq_red_or.sv
// Combinational OR-reduction of one chunk.
module red_or_seq_red_or #(
   parameter int Width = 8
) (
   input  logic [Width-1:0] a_i,
   output logic             z_o
);

   assign z_o = |a_i;

endmodule

// File: rtl/red_or_seq.sv
// Word-serial OR-reduction: scans the operand one chunk per cycle through a
// single reducer, keeping a sticky OR and the index of the first non-zero chunk.
module red_or_seq
   import red_or_seq_pkg::*;
#(
   parameter int TotalWidth = 64,
   parameter int ChunkWidth = 8,
   parameter int EarlyExit  = 1
) (
   input  logic                                                clk_i,
   input  logic                                                rst_ni,
   input  logic [TotalWidth-1:0]                               a_i,
   input  logic                                                a_valid_i,
   output logic                                                a_ready_o,
   output logic                                                z_o,
   output logic [idx_width(ceil_div(TotalWidth, ChunkWidth))-1:0] idx_o,
   output logic                                                z_valid_o,
   input  logic                                                z_ready_i,
   output logic                                                busy_o
);

   localparam int NumChunks = ceil_div(TotalWidth, ChunkWidth);
   localparam int IdxWidth  = idx_width(NumChunks);
   localparam int PadWidth  = NumChunks * ChunkWidth;
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumChunks - 1);

   generate
      if (ChunkWidth < 1) begin : g_bad_chunk
         $error("red_or_seq: ChunkWidth must be >= 1");
      end
      if (TotalWidth < ChunkWidth) begin : g_bad_total
         $error("red_or_seq: TotalWidth must be >= ChunkWidth");
      end
   endgenerate

   state_e                state_q;
   logic [PadWidth-1:0]   op_q, op_d;
   logic [IdxWidth-1:0]   cnt_q;
   logic [IdxWidth-1:0]   idx_q;
   logic                  acc_q, acc_d;
   logic                  z_q, z_valid_q, busy_q;
   logic [ChunkWidth-1:0] slice;
   logic                  slice_or;
   logic                  last_step;

   // Pad the operand register up to whole chunks so the last slice reads zeros.
   always_comb begin
      op_d = '0;
      op_d[TotalWidth-1:0] = a_i;
   end

   always_comb begin
      slice = '0;
      for (int i = 0; i < NumChunks; i++) begin
         if (cnt_q == IdxWidth'(i)) slice = op_q[i*ChunkWidth +: ChunkWidth];
      end
   end

   red_or_seq_red_or #(
      .Width (ChunkWidth)
   ) u_red_or (
      .a_i (slice),
      .z_o (slice_or)
   );

   assign acc_d     = acc_q | slice_or;
   assign last_step = (cnt_q == LastIdx) || ((EarlyExit != 0) && slice_or);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         op_q      <= '0;
         cnt_q     <= '0;
         acc_q     <= 1'b0;
         idx_q     <= '0;
         z_q       <= 1'b0;
         z_valid_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (a_valid_i) begin
                  op_q    <= op_d;
                  cnt_q   <= '0;
                  acc_q   <= 1'b0;
                  idx_q   <= '0;
                  z_q     <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               acc_q <= acc_d;
               // acc_q doubles as the "already hit" flag, so idx is captured once.
               if (slice_or && !acc_q) idx_q <= cnt_q;
               if (last_step) begin
                  z_q       <= acc_d;
                  z_valid_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= DONE;
               end else begin
                  cnt_q <= cnt_q + IdxWidth'(1);
               end
            end
            DONE: begin
               if (z_ready_i) begin
                  z_valid_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign a_ready_o = (state_q == IDLE);
   assign z_o       = z_q;
   assign idx_o     = idx_q;
   assign z_valid_o = z_valid_q;
   assign busy_o    = busy_q;

endmodule
